mux_nto1_rr: RTL

Parametrised N:1 channel multiplexer with a registered, valid/ready-handshaked output stage. It is the successor to the team's combinational 4:1 bit mux and generalises it in three ways: N channels, W-bit data, and a round-robin arbitration mode alongside fixed select. It sits between multiple producer channels and a single downstream consumer, with one-cycle latency and full throughput.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 73 +++++++
 rtl/mux_nto1_rr.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pkg
//  Purpose  : Shared definitions for the N:1 round-robin channel multiplexer.
//             Holds the mode encoding and a wrap-around index increment helper.
//  Revision : 1.0  initial release
// ============================================================================
package mux_pkg;

  // Mode encoding driven on the mux 'mode' port
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next channel index after idx, wrapping from n-1 back to 0
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter. Searches the request vector from the
//             priority pointer upward (wrapping at N-1 -> 0) and grants the
//             first set request. Owns the pointer register, which moves to
//             one past the granted channel whenever 'advance' is asserted.
//
//  Ports    : clk      in   clock, state on rising edge
//             rst_n    in   asynchronous active-low reset (pointer -> 0)
//             req      in   N  per-channel request
//             advance  in   1  grant was consumed this cycle; move pointer
//             gnt      out  N  one-hot grant (all zero when no request)
//             gnt_idx  out  SELW  index of the granted channel
//             any      out  1  at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  localparam logic [SELW:0] NL = (SELW+1)'(N);

  logic [SELW-1:0] r_ptr;
  logic [SELW:0]   w_cand;

  // Walk N candidates starting at the pointer; the first set request wins.
  // The candidate index carries one extra bit so the wrap test cannot overflow.
  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, r_ptr} + (SELW+1)'(k);
      if (w_cand >= NL) begin
        w_cand = w_cand - NL;
      end
      if (!any && req[w_cand[SELW-1:0]]) begin
        any     = 1'b1;
        gnt_idx = w_cand[SELW-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  // Pointer only moves on a consumed grant, so a stalled grant keeps priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= SELW'(wrap_inc(int'(gnt_idx), N));
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mux_nto1_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mux_nto1_rr
//  Purpose  : N:1 channel multiplexer with a registered valid/ready output
//             stage. Selects a channel either by a fixed select or by
//             round-robin arbitration; one-cycle latency, full throughput.
//
//  Ports    : clk        in   clock, state on rising edge
//             rst_n      in   asynchronous active-low reset
//             mode       in   1     0 = fixed select, 1 = round-robin
//             sel        in   SELW  channel forwarded in fixed mode
//             in_valid   in   N     per-channel valid
//             in_data    in   N*W   channel i at bits [i*W +: W]
//             in_ready   out  N     per-channel ready, at most one bit set
//             out_valid  out  1     output register holds an item
//             out_data   out  W     registered data
//             out_chan   out  SELW  channel that supplied out_data
//             out_ready  in   1     consumer accepts when out_valid high
//  Revision : 1.0  initial release
// ============================================================================
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 1,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  input  logic            out_ready
);

  localparam int            NSEL = 1 << SELW;
  localparam logic [SELW:0] NL   = (SELW+1)'(N);

  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_chan;

  logic            w_load_en;
  logic [NSEL-1:0] w_valid_ext;
  logic            w_fix_ok;
  logic            w_grant_valid;
  logic [SELW-1:0] w_grant_idx;
  logic            w_transfer;
  logic            w_advance;
  logic [W-1:0]    w_data;

  logic [N-1:0]    w_arb_gnt;
  logic [SELW-1:0] w_arb_idx;
  logic            w_arb_any;

  // Register can take a new item when empty or when it drains this cycle
  assign w_load_en = !r_out_valid || out_ready;

  // Valid vector padded to the full select range so a select beyond N-1
  // reads a zero instead of indexing past the port
  always_comb begin
    w_valid_ext        = '0;
    w_valid_ext[N-1:0] = in_valid;
  end

  assign w_fix_ok = ({1'b0, sel} < NL) && w_valid_ext[sel];

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (w_advance),
    .gnt     (w_arb_gnt),
    .gnt_idx (w_arb_idx),
    .any     (w_arb_any)
  );

  always_comb begin
    if (mode == MODE_RR) begin
      w_grant_valid = w_arb_any;
      w_grant_idx   = w_arb_idx;
    end else begin
      w_grant_valid = w_fix_ok;
      w_grant_idx   = sel;
    end
  end

  // A grant always implies in_valid on that channel, so ready-and-grant is
  // already the full transfer condition
  assign w_transfer = rst_n && w_load_en && w_grant_valid;

  // Only round-robin transfers move the pointer; fixed-mode traffic leaves it
  // where the last round-robin grant put it
  assign w_advance  = w_transfer && (mode == MODE_RR);

  always_comb begin
    in_ready = '0;
    if (w_transfer) begin
      if (mode == MODE_RR) begin
        in_ready = w_arb_gnt;
      end else begin
        in_ready[w_grant_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant_idx == SELW'(i)) begin
        w_data = in_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_transfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_chan  <= w_grant_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule : mux_nto1_rr
`default_nettype wire
